// File: rtl/decade_run_ctrl_pkg.sv
// decade_run_ctrl_pkg: shared types and helpers for the decade run controller.
//   state_t   - controller states
//   BCD_MAX   - largest legal BCD digit value
//   bcd_valid - true when a nibble is a legal BCD digit
package decade_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/decade_digit.sv
// decade_digit: one synchronous mod-10 counter stage of the cascade.
//   clk       in  system clock
//   clr       in  synchronous active-low reset
//   clear     in  synchronous clear to zero (restart)
//   inc       in  advance this digit by one this cycle
//   q         out current digit value (0..9)
//   carry_out out advance request for the next digit (inc while at 9)
module decade_digit
  import decade_run_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry_out
);

  // digit register: reset, clear, or modulo-10 increment
  always_ff @(posedge clk) begin
    if (!clr) begin
      q <= 4'd0;
    end else if (clear) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end else begin
      q <= q;
    end
  end

  assign carry_out = inc & (q == BCD_MAX);

endmodule

// File: rtl/decade_run_ctrl.sv
// decade_run_ctrl: run/pause/lap controller over a synchronous BCD cascade.
//   clk        in  system clock
//   clr        in  synchronous active-low reset
//   start      in  clear count and run (ignored while target is not BCD)
//   pause      in  toggle RUN <-> PAUSE
//   lap        in  snapshot count into lap_q (RUN/PAUSE only)
//   target     in  BCD stop value, LSD at [3:0]
//   count      out current BCD count
//   lap_q      out last lap snapshot
//   running    out high while in RUN
//   done       out one-cycle pulse after the target is reached
//   target_err out combinational, any target nibble > 9
module decade_run_ctrl
  import decade_run_ctrl_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  lap,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   lap_q,
  output logic                  running,
  output logic                  done,
  output logic                  target_err
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  state_t        state_r, state_n;
  logic [PW-1:0] pre_r;
  logic [W-1:0]  lap_r;
  logic          running_r;
  logic          done_r;

  logic [W-1:0]  count_s;
  logic [W-1:0]  next_s;
  logic [DIGITS:0] inc_s;
  logic          err_s;
  logic          start_ok_s;
  logic          tick_s;
  logic          hit_s;
  logic          wrap_unused_s;

  // any non-BCD nibble in target flags an error
  always_comb begin
    err_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(target[4*i +: 4])) begin
        err_s = 1'b1;
      end else begin
        err_s = err_s;
      end
    end
  end

  assign start_ok_s = start & ~err_s;
  // a pending start or pause steals the tick so the prescaler phase is preserved
  assign tick_s = (state_r == RUN) & (pre_r == PRE_LAST) & ~start_ok_s & ~pause;

  // BCD increment of the current count, used for the target compare
  always_comb begin
    logic carry;
    logic [3:0] nib;
    carry  = 1'b1;
    nib    = 4'd0;
    next_s = count_s;
    for (int i = 0; i < DIGITS; i++) begin
      nib = count_s[4*i +: 4];
      if (carry) begin
        next_s[4*i +: 4] = (nib == BCD_MAX) ? 4'd0 : nib + 4'd1;
        carry = (nib == BCD_MAX);
      end else begin
        next_s[4*i +: 4] = nib;
      end
    end
  end

  assign hit_s = tick_s & ~err_s & (next_s == target);

  assign inc_s[0] = tick_s;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      decade_digit u_digit (
        .clk       (clk),
        .clr       (clr),
        .clear     (start_ok_s),
        .inc       (inc_s[g]),
        .q         (count_s[4*g +: 4]),
        .carry_out (inc_s[g+1])
      );
    end
  endgenerate

  // full-cascade wrap has no consumer; the compare works on next_s
  assign wrap_unused_s = inc_s[DIGITS];

  // next-state logic; a valid start overrides everything else
  always_comb begin
    state_n = state_r;
    if (start_ok_s) begin
      state_n = RUN;
    end else begin
      case (state_r)
        IDLE:    state_n = IDLE;
        RUN: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (hit_s) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end
        PAUSE: begin
          if (pause) begin
            state_n = RUN;
          end else begin
            state_n = PAUSE;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // state, prescaler, lap snapshot and registered status outputs
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r   <= IDLE;
      pre_r     <= '0;
      lap_r     <= '0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      running_r <= (state_n == RUN);
      done_r    <= hit_s;
      if (start_ok_s) begin
        pre_r <= '0;
      end else if ((state_r == RUN) && !pause) begin
        pre_r <= (pre_r == PRE_LAST) ? '0 : pre_r + PW'(1);
      end else begin
        pre_r <= pre_r;
      end
      // count_s is still the pre-increment value on a coinciding tick
      if (lap && ((state_r == RUN) || (state_r == PAUSE))) begin
        lap_r <= count_s;
      end else begin
        lap_r <= lap_r;
      end
    end
  end

  assign count      = count_s;
  assign lap_q      = lap_r;
  assign running    = running_r;
  assign done       = done_r;
  assign target_err = err_s;

endmodule
